// File: rtl/pixel_window_2x2.sv
// 2x2 sliding-window generator for a raster-order 8-bit pixel stream.
// A one-row line buffer supplies the previous row; windows never straddle a row boundary.
module pixel_window_2x2 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] win_tl,
  output logic [7:0] win_tr,
  output logic [7:0] win_bl,
  output logic [7:0] win_br,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_cur_d;
  logic [7:0]    r_above_d;
  logic [7:0]    r_win_tl;
  logic [7:0]    r_win_tr;
  logic [7:0]    r_win_bl;
  logic [7:0]    r_win_br;
  logic          r_win_valid;
  logic          r_frame_done;

  logic [7:0]    r_line_mem [IMG_W];

  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_next;
  logic [RW-1:0] w_row_next;
  logic          w_window;
  logic          w_last_pix;

  // sof overrides the counters so the current pixel is always taken as (0,0).
  assign w_accept   = pix_valid;
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_window   = w_accept && (w_row != '0) && (w_col != '0);
  assign w_last_pix = (w_row == LAST_ROW) && (w_col == LAST_COL);

  always_comb begin
    w_col_next = w_col + 1'b1;
    w_row_next = w_row;
    if (w_col == LAST_COL) begin
      w_col_next = '0;
      w_row_next = (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
    end
  end

  // Line buffer holds no reset so it can map onto block RAM; row-0 gating hides stale data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line_mem[w_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_cur_d      <= '0;
      r_above_d    <= '0;
      r_win_tl     <= '0;
      r_win_tr     <= '0;
      r_win_bl     <= '0;
      r_win_br     <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_window;
      r_frame_done <= w_window && w_last_pix;
      if (w_accept) begin
        r_col     <= w_col_next;
        r_row     <= w_row_next;
        r_cur_d   <= pix_in;
        r_above_d <= r_line_mem[w_col];
      end
      // The read of r_line_mem here sees the value from before this cycle's write.
      if (w_window) begin
        r_win_tl <= r_above_d;
        r_win_tr <= r_line_mem[w_col];
        r_win_bl <= r_cur_d;
        r_win_br <= pix_in;
      end
    end
  end

  assign win_tl     = r_win_tl;
  assign win_tr     = r_win_tr;
  assign win_bl     = r_win_bl;
  assign win_br     = r_win_br;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule
